// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared definitions for the two-requester ALU arbiter: 4-bit
//               ALU opcodes, the arbiter FSM state encoding, the requester-id
//               type and a helper that flags the multi-cycle opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_SHL1 = 4'b0100;
   localparam logic [3:0] OP_SHR1 = 4'b0101;
   localparam logic [3:0] OP_ROTL = 4'b0110;
   localparam logic [3:0] OP_ROTR = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1011;
   localparam logic [3:0] OP_NAND = 4'b1100;
   localparam logic [3:0] OP_XNOR = 4'b1101;
   localparam logic [3:0] OP_GT   = 4'b1110;
   localparam logic [3:0] OP_EQ   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef logic req_id_t;

   // Multiply and divide occupy the configurable multi-cycle EXEC window.
   function automatic logic is_muldiv(input logic [3:0] sel);
      return (sel == OP_MUL) || (sel == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational WIDTH-bit unsigned ALU.
//               i_a, i_b : operands
//               i_sel    : 4-bit opcode (see alu_arbiter_pkg)
//               o_y      : result, truncated to WIDTH bits
//               Divide by zero returns 0 here; the caller overrides it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_sel,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = '0;
      case (i_sel)
         OP_ADD  : o_y = i_a + i_b;
         OP_SUB  : o_y = i_a - i_b;
         OP_MUL  : o_y = i_a * i_b;
         OP_DIV  : o_y = (i_b == '0) ? '0 : (i_a / i_b);
         OP_SHL1 : o_y = i_a << 1;
         OP_SHR1 : o_y = i_a >> 1;
         OP_ROTL : o_y = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
         OP_ROTR : o_y = {i_a[0], i_a[WIDTH-1:1]};
         OP_AND  : o_y = i_a & i_b;
         OP_OR   : o_y = i_a | i_b;
         OP_XOR  : o_y = i_a ^ i_b;
         OP_NOR  : o_y = ~(i_a | i_b);
         OP_NAND : o_y = ~(i_a & i_b);
         OP_XNOR : o_y = ~(i_a ^ i_b);
         OP_GT   : o_y = {{(WIDTH-1){1'b0}}, (i_a > i_b)};
         OP_EQ   : o_y = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
         default : o_y = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one ALU between two requesters.
//               One operation in flight at a time: IDLE -> EXEC -> RESP.
//               clk, rst                 : clock, synchronous active-high reset
//               reqN_valid / reqN_ready  : requester handshake (N = 0, 1)
//               reqN_a, reqN_b, reqN_sel : operands and opcode
//               res_valid / res_ready    : result handshake
//               res_data, res_zero       : result and zero flag
//               res_err                  : divide by zero
//               res_id                   : requester owning the result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH         = 64,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_sel,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_err,
   output logic             res_id
);

   // Counter is loaded with "cycles remaining after this one".
   localparam logic [3:0] c_MD_LAST = 4'(MULDIV_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   req_id_t          r_rr_ptr;      // requester preferred when both are valid
   req_id_t          r_id;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_sel;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_zero;
   logic             r_res_err;
   req_id_t          r_res_id;

   req_id_t          w_gnt_id;
   logic             w_hs;
   logic             w_exec_last;
   logic             w_res_take;
   logic             w_div0;
   logic [WIDTH-1:0] w_alu_y;
   logic [WIDTH-1:0] w_cap_a;
   logic [WIDTH-1:0] w_cap_b;
   logic [3:0]       w_cap_sel;

   // Grant is purely combinational; the pointer only moves on an actual
   // handshake, so a requester dropping valid early leaves it untouched.
   always_comb begin
      w_gnt_id = req1_valid;
      if (req0_valid && req1_valid) begin
         w_gnt_id = r_rr_ptr;
      end
   end

   assign w_hs        = !rst && (r_state == ST_IDLE) && (req0_valid || req1_valid);
   assign req0_ready  = w_hs && (w_gnt_id == 1'b0);
   assign req1_ready  = w_hs && (w_gnt_id == 1'b1);
   assign w_cap_a     = w_gnt_id ? req1_a   : req0_a;
   assign w_cap_b     = w_gnt_id ? req1_b   : req0_b;
   assign w_cap_sel   = w_gnt_id ? req1_sel : req0_sel;
   assign w_exec_last = (r_state == ST_EXEC) && (r_cnt == 4'd0);
   assign w_res_take  = (r_state == ST_RESP) && r_res_valid && res_ready;
   assign w_div0      = (r_sel == OP_DIV) && (r_b == '0);

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .i_a   (r_a),
      .i_b   (r_b),
      .i_sel (r_sel),
      .o_y   (w_alu_y)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE : if (w_hs)        w_state_nxt = ST_EXEC;
         ST_EXEC : if (w_exec_last) w_state_nxt = ST_RESP;
         ST_RESP : if (w_res_take)  w_state_nxt = ST_IDLE;
         default :                  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= 1'b0;
         r_id        <= 1'b0;
         r_cnt       <= 4'd0;
         r_a         <= '0;
         r_b         <= '0;
         r_sel       <= 4'd0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_zero  <= 1'b0;
         r_res_err   <= 1'b0;
         r_res_id    <= 1'b0;
      end else begin
         if (w_hs) begin
            r_a      <= w_cap_a;
            r_b      <= w_cap_b;
            r_sel    <= w_cap_sel;
            r_id     <= w_gnt_id;
            r_rr_ptr <= ~w_gnt_id;
            r_cnt    <= is_muldiv(w_cap_sel) ? c_MD_LAST : 4'd0;
         end
         if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_exec_last) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_id;
            if (w_div0) begin
               r_res_data <= '1;
               r_res_zero <= 1'b0;
               r_res_err  <= 1'b1;
            end else begin
               r_res_data <= w_alu_y;
               r_res_zero <= (w_alu_y == '0);
               r_res_err  <= 1'b0;
            end
         end
         if (w_res_take) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_zero  = r_res_zero;
   assign res_err   = r_res_err;
   assign res_id    = r_res_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter (WIDTH=64,
//               MULDIV_CYCLES=4): table of single-requester operations plus
//               hand-written round-robin, result-hold and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]    req0_sel = 4'd0, req1_sel = 4'd0;
   logic          res_valid, res_ready = 1'b0;
   logic [W-1:0]  res_data;
   logic          res_zero, res_err, res_id;

   int n_cmp = 0;
   int n_bad = 0;

   alu_arbiter #(.WIDTH(W), .MULDIV_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero(res_zero), .res_err(res_err),
      .res_id(res_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         id;
      logic [3:0]   sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      logic         ez;
      logic         ee;
      int           lat;
   } vec_t;

   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] MSB1 = 64'h8000_0000_0000_0001;

   vec_t tbl[21];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Waits for the currently visible ready (bounded); leaves time just after
   // the handshake edge. Returns the granted id.
   task automatic wait_grant(input string nm, output logic gid, output bit ok);
      ok  = 1'b0;
      gid = 1'b0;
      #1;
      for (int n = 0; n < 10; n++) begin
         if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
            ok  = 1'b1;
            gid = req1_ready;
            break;
         end
         tick();
         #1;
      end
      chk({nm, "_grant_seen"}, {63'd0, ok}, 64'd1);
      if (ok) tick();
   endtask

   task automatic wait_result(output int k);
      k = 0;
      while (res_valid !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic  gid;
      bit    ok;
      int    k;
      string nm;
      nm = $sformatf("vec%0d", idx);
      res_ready  = 1'b1;
      req0_valid = (v.id == 1'b0);
      req1_valid = (v.id == 1'b1);
      req0_a = v.a; req0_b = v.b; req0_sel = v.sel;
      req1_a = v.a; req1_b = v.b; req1_sel = v.sel;
      wait_grant(nm, gid, ok);
      if (!ok) return;
      chk({nm, "_gid"}, {63'd0, gid}, {63'd0, v.id});
      // Scramble inputs after the handshake: the captured copy must be used.
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~v.a; req0_b = ~v.b; req0_sel = ~v.sel;
      req1_a = ~v.a; req1_b = ~v.b; req1_sel = ~v.sel;
      #1;
      chk({nm, "_ready_after_hs"}, {62'd0, req1_ready, req0_ready}, 64'd0);
      wait_result(k);
      chk({nm, "_latency"}, 64'(k), 64'(v.lat));
      chk({nm, "_data"}, res_data, v.exp);
      chk({nm, "_zero"}, {63'd0, res_zero}, {63'd0, v.ez});
      chk({nm, "_err"},  {63'd0, res_err},  {63'd0, v.ee});
      chk({nm, "_id"},   {63'd0, res_id},   {63'd0, v.id});
      tick();
      chk({nm, "_valid_cleared"}, {63'd0, res_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic  gid, snap_id, snap_z, snap_e;
      logic [W-1:0] snap_d;
      bit    ok;
      int    k;

      //            id    sel      a                     b               exp                   ez ee lat
      tbl[0]  = '{1'b0, 4'b0000, 64'd5,               64'd7,          64'd12,               0, 0, 1};
      tbl[1]  = '{1'b1, 4'b0001, 64'd3,               64'd3,          64'd0,                1, 0, 1};
      tbl[2]  = '{1'b0, 4'b0001, 64'd0,               64'd1,          ONES,                 0, 0, 1};
      tbl[3]  = '{1'b1, 4'b0010, 64'h1_0000_0000,     64'h1_0000_0000, 64'd0,               1, 0, 4};
      tbl[4]  = '{1'b0, 4'b0010, 64'd3,               64'd5,          64'd15,               0, 0, 4};
      tbl[5]  = '{1'b0, 4'b0011, 64'd9,               64'd0,          ONES,                 0, 1, 4};
      tbl[6]  = '{1'b0, 4'b0011, 64'd9,               64'd2,          64'd4,                0, 0, 4};
      tbl[7]  = '{1'b1, 4'b0100, MSB1,                64'd0,          64'd2,                0, 0, 1};
      tbl[8]  = '{1'b0, 4'b0101, MSB1,                64'd0,          64'h4000_0000_0000_0000, 0, 0, 1};
      tbl[9]  = '{1'b1, 4'b0110, MSB1,                64'd0,          64'd3,                0, 0, 1};
      tbl[10] = '{1'b0, 4'b0111, 64'd1,               64'd0,          64'h8000_0000_0000_0000, 0, 0, 1};
      tbl[11] = '{1'b1, 4'b1000, 64'hF0F0,            64'hFF00,       64'hF000,             0, 0, 1};
      tbl[12] = '{1'b0, 4'b1001, 64'hF0F0,            64'h0F00,       64'hFFF0,             0, 0, 1};
      tbl[13] = '{1'b1, 4'b1010, 64'hFF00,            64'h0FF0,       64'hF0F0,             0, 0, 1};
      tbl[14] = '{1'b0, 4'b1011, 64'd0,               64'd0,          ONES,                 0, 0, 1};
      tbl[15] = '{1'b1, 4'b1100, ONES,                ONES,           64'd0,                1, 0, 1};
      tbl[16] = '{1'b0, 4'b1101, 64'hF,               64'hF,          ONES,                 0, 0, 1};
      tbl[17] = '{1'b1, 4'b1110, 64'd5,               64'd3,          64'd1,                0, 0, 1};
      tbl[18] = '{1'b0, 4'b1110, 64'd3,               64'd5,          64'd0,                1, 0, 1};
      tbl[19] = '{1'b1, 4'b1111, 64'd7,               64'd7,          64'd1,                0, 0, 1};
      tbl[20] = '{1'b0, 4'b1111, 64'd7,               64'd8,          64'd0,                1, 0, 1};

      // Reset state, with both requesters asking: no ready may appear.
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_ready",  {62'd0, req1_ready, req0_ready}, 64'd0);
      chk("rst_valid",  {63'd0, res_valid}, 64'd0);
      chk("rst_data",   res_data, 64'd0);
      chk("rst_flags",  {61'd0, res_zero, res_err, res_id}, 64'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;
      tick();

      for (int i = 0; i < 21; i++) begin
         run_vec(i, tbl[i]);
      end

      // Round robin: both valid continuously, sub 3-3.
      do_reset();
      res_ready  = 1'b1;
      req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd3; req0_sel = 4'b0001;
      req1_valid = 1'b1; req1_a = 64'd3; req1_b = 64'd3; req1_sel = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         wait_grant($sformatf("rr%0d", i), gid, ok);
         if (!ok) break;
         chk($sformatf("rr%0d_gid", i), {63'd0, gid}, 64'(i % 2));
         wait_result(k);
         chk($sformatf("rr%0d_latency", i), 64'(k), 64'd1);
         chk($sformatf("rr%0d_data", i), res_data, 64'd0);
         chk($sformatf("rr%0d_zero", i), {63'd0, res_zero}, 64'd1);
         chk($sformatf("rr%0d_id", i), {63'd0, res_id}, 64'(i % 2));
         tick();
      end

      // Result held in RESP while res_ready stays low.
      do_reset();
      res_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 64'd10; req0_b = 64'd20; req0_sel = 4'b0000;
      req1_valid = 1'b1; req1_a = 64'd10; req1_b = 64'd20; req1_sel = 4'b0000;
      wait_grant("hold", gid, ok);
      wait_result(k);
      chk("hold_data", res_data, 64'd30);
      chk("hold_id", {63'd0, res_id}, 64'd0);
      snap_d = res_data; snap_id = res_id; snap_z = res_zero; snap_e = res_err;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("hold%0d_state", i),
             {res_valid, res_zero, res_err, res_id, req0_ready, req1_ready},
             {1'b1, snap_z, snap_e, snap_id, 1'b0, 1'b0});
         chk($sformatf("hold%0d_data", i), res_data, snap_d);
      end
      res_ready = 1'b1;
      tick();
      #1;
      chk("hold_release_valid", {63'd0, res_valid}, 64'd0);
      chk("hold_release_ready", {63'd0, (req0_ready | req1_ready)}, 64'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // Reset in the second EXEC cycle of a req0 divide.
      do_reset();
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd3; req0_sel = 4'b0011;
      wait_grant("rstx", gid, ok);
      req0_valid = 1'b0;
      tick();                      // now in second EXEC cycle
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_sel = 4'b0000;
      req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd2; req1_sel = 4'b0000;
      #1;
      chk("rstx_ready_in_rst", {62'd0, req1_ready, req0_ready}, 64'd0);
      tick();
      chk("rstx_valid", {63'd0, res_valid}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rstx_grant0", {62'd0, req1_ready, req0_ready}, 64'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_result(k);
      chk("rstx_latency", 64'(k), 64'd1);
      chk("rstx_data", res_data, 64'd3);
      chk("rstx_id", {63'd0, res_id}, 64'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width.
REQ-002 The block SHALL have parameter MULDIV_CYCLES, default 4, giving the EXEC cycles used by multiply and divide; legal values are 1..15.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port req0_valid / req1_valid, input, 1 each, requester operation valid.
REQ-006 The block SHALL have port req0_ready / req1_ready, output, 1 each, operation accepted this cycle.
REQ-007 The block SHALL have port reqN_a / reqN_b, input, WIDTH each, operands.
REQ-008 The block SHALL have port reqN_sel, input, 4, ALU opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 shl1, 0101 shr1, 0110 rotl, 0111 rotr, 1000 and, 1001 or, 1010 xor, 1011 nor, 1100 nand, 1101 xnor, 1110 A>B, 1111 A==B.
REQ-009 The block SHALL have port res_valid, output, 1, result valid.
REQ-010 The block SHALL have port res_ready, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port res_data, output, WIDTH, result.
REQ-012 The block SHALL have port res_zero, output, 1, res_data equals 0.
REQ-013 The block SHALL have port res_err, output, 1, divide by zero.
REQ-014 The block SHALL have port res_id, output, 1, index of the requester that owns the result.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP; transitions are IDLE->EXEC on handshake, EXEC->RESP on the last EXEC cycle, and RESP->IDLE on res_valid&&res_ready.
REQ-016 In IDLE, reqN_ready SHALL be 1 only for the granted requester N, and only when reqN_valid=1; all ready outputs are 0 in EXEC and RESP.
REQ-017 Grant SHALL be round-robin: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted.
REQ-018 On a handshake, the block SHALL capture a, b, sel and id into internal registers; requesters may change their inputs from the next cycle.
REQ-019 EXEC SHALL last 1 cycle for all opcodes except 0010 and 0011, which last MULDIV_CYCLES cycles, counted by a down-counter.
REQ-020 At the end of the last EXEC cycle, the block SHALL register the ALU output into res_data, the zero compare into res_zero, and 0 into res_err.
REQ-021 For a handshake at edge t, res_valid SHALL first be high in the cycle after edge t+N, where N is the number of EXEC cycles.
REQ-022 Divide by zero (sel=0011, b=0) SHALL produce res_data all ones, res_err=1 and res_zero=0.
REQ-023 Rotate opcodes SHALL rotate the full WIDTH by one bit, not the low byte.
REQ-024 Compare opcodes SHALL return a WIDTH-bit result of 1 or 0.
REQ-025 All arithmetic SHALL be unsigned and truncated to WIDTH bits; mul keeps the low WIDTH bits and sub wraps modulo 2^WIDTH.
REQ-026 In RESP, res_valid, res_data, res_zero, res_err and res_id SHALL hold stable until res_ready; res_ready seen outside RESP is ignored.
REQ-027 A requester that drops valid before its handshake SHALL lose its grant cleanly: no capture and no change to the round-robin pointer.
REQ-028 Throughput SHALL be at most one operation per N+2 cycles; no new operation is accepted while an operation is in EXEC or RESP.

Reset
REQ-029 While rst=1, the block SHALL enter IDLE and clear res_valid, res_data, res_zero, res_err, res_id, the EXEC counter and the captured registers to 0, and point the round-robin pointer at requester 0.
REQ-030 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation with no result delivered, and ready outputs SHALL be 0 during reset.

Structure
REQ-031 A shared package SHALL hold the 4-bit opcode constants, the FSM state enum and the requester-id type.
REQ-032 The block SHALL instantiate one combinational sub-module alu_core, the team's WIDTH-parameterised ALU; divide-by-zero override and zero-flag registration stay in alu_arbiter.

Verification
REQ-033 The bench SHALL cover: req0 add a=5, b=7 with res_ready=1 -> req0_ready one cycle, res_valid two cycles later, res_data=12, res_zero=0, res_id=0.
REQ-034 The bench SHALL cover: both requesters valid continuously with sub a=3, b=3 -> grants alternate 0,1,0,1; every result has res_data=0 and res_zero=1.
REQ-035 The bench SHALL cover: req1 mul a=2^32, b=2^32 with MULDIV_CYCLES=4 -> res_valid 4 cycles after EXEC entry, res_data=0, res_zero=1.
REQ-036 The bench SHALL cover: div a=9, b=0 -> res_data=all ones, res_err=1, res_zero=0; then div a=9, b=2 -> res_data=4, res_err=0.
REQ-037 The bench SHALL cover: res_ready held 0 for 10 cycles in RESP -> outputs stable and req0_ready/req1_ready stay 0; after res_ready=1, the block returns to IDLE.
REQ-038 The bench SHALL cover: rst asserted during the second EXEC cycle of a div -> next cycle is IDLE with res_valid=0, no result emitted, and requester 0 is granted first afterwards.
